// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Requester-side bus of the shared UART transmitter arbiter. Requester r
// occupies bit r of the per-requester vectors and slice [r*W +: W] of the
// packed data/conf buses.
//
//   req_valid  requester -> arbiter   request pending, one bit per requester
//   req_data   requester -> arbiter   character, MAX_UART_DATA_W per requester
//   req_conf   requester -> arbiter   frame conf {data[1:0], stop[1:0], parity_en}
//   req_lock   requester -> arbiter   keep priority after own frame
//                                     (only with UART_TX_ARB_LOCK_EN defined)
//   req_ready  arbiter -> requester   one-hot accept strobe, combinational
//   req_done   arbiter -> requester   one-cycle pulse when the frame is sent
//
// Modports: master = requester side, slave = arbiter side.
// Optional macro: UART_TX_ARB_LOCK_EN adds req_lock.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ          = 4,
  parameter int MAX_UART_DATA_W  = 8,
  parameter int TOTAL_CONF_WIDTH = 5
);

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ*MAX_UART_DATA_W-1:0]  req_data;
  logic [NUM_REQ*TOTAL_CONF_WIDTH-1:0] req_conf;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ-1:0]                  req_done;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]                  req_lock;
`endif

  modport master (
`ifdef UART_TX_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_data, req_conf,
    input  req_ready, req_done
  );

  modport slave (
`ifdef UART_TX_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_data, req_conf,
    output req_ready, req_done
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter and sequencer that shares one tx_module UART
// transmitter between NUM_REQ requesters. The winning request is captured,
// presented to tx_module with a held start strobe, tracked through
// tx_busy/tx_done, and completion is reported back to its owner.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   req_if      requester bus (uart_tx_arbiter_if.slave)
//   tx_start_o  start strobe to tx_module, held until tx_busy_i is seen
//   tx_data_o   captured character, stable until the next capture
//   tx_conf_o   captured frame conf, stable until the next capture
//   tx_busy_i   tx_module busy
//   tx_done_i   tx_module done (may stay high for up to one baud tick)
//   grant_id_o  current or last owner
//   arb_busy_o  high whenever the FSM is not IDLE
//
// Optional macro: UART_TX_ARB_LOCK_EN. When defined, a requester whose
// req_lock bit is set at frame completion keeps top priority.
//
// State      | Meaning
// -----------+---------------------------------------------------------------
// IDLE       | no frame owned; grant the rr_ptr-ordered winner if any valid
// START      | tx_start_o held high until tx_module reports busy
// WAIT_DONE  | frame on the line; wait for done with busy low, then report
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int MAX_UART_DATA_W  = 8,
  parameter int TOTAL_CONF_WIDTH = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  uart_tx_arbiter_if.slave             req_if,
  output logic                         tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]   tx_data_o,
  output logic [TOTAL_CONF_WIDTH-1:0]  tx_conf_o,
  input  logic                         tx_busy_i,
  input  logic                         tx_done_i,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
  output logic                         arb_busy_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } state_t;

  state_t                        state_q;
  logic [ID_W-1:0]               rr_ptr_q;
  logic [ID_W-1:0]               rr_ptr_d;
  logic [ID_W-1:0]               grant_id_q;
  logic                          tx_start_q;
  logic                          arb_busy_q;
  logic [MAX_UART_DATA_W-1:0]    tx_data_q;
  logic [TOTAL_CONF_WIDTH-1:0]   tx_conf_q;
  logic [NUM_REQ-1:0]            req_done_q;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          win_found;
  logic [ID_W-1:0]               win_id;

  // Explicit modulo add so non-power-of-2 NUM_REQ wraps at NUM_REQ-1.
  function automatic logic [ID_W-1:0] ptr_add(input logic [ID_W-1:0] base,
                                               input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // First valid requester at or above rr_ptr, with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_if.req_valid[ptr_add(rr_ptr_q, i)]) begin
        win_found = 1'b1;
        win_id    = ptr_add(rr_ptr_q, i);
      end
    end
  end

  // Pointer loaded on frame completion.
  always_comb begin
    if (grant_id_q == ID_W'(NUM_REQ - 1)) rr_ptr_d = '0;
    else                                  rr_ptr_d = grant_id_q + 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
    if (req_if.req_lock[grant_id_q]) rr_ptr_d = grant_id_q;
`endif
  end

  // No grant while the done pulse of the previous frame is out, so the next
  // START always comes at least one cycle after req_done.
  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && !rst_i && !(|req_done_q) && win_found)
      req_ready[win_id] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_start_q <= 1'b0;
      arb_busy_q <= 1'b0;
      tx_data_q  <= '0;
      tx_conf_q  <= '0;
      req_done_q <= '0;
    end else begin
      req_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_ready) begin
            tx_data_q  <= req_if.req_data[int'(win_id)*MAX_UART_DATA_W +: MAX_UART_DATA_W];
            tx_conf_q  <= req_if.req_conf[int'(win_id)*TOTAL_CONF_WIDTH +: TOTAL_CONF_WIDTH];
            grant_id_q <= win_id;
            tx_start_q <= 1'b1;
            arb_busy_q <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          // tx_module samples start only on baud ticks; a stale tx_done from
          // the previous frame is deliberately not looked at here.
          if (tx_busy_i) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done_i && !tx_busy_i) begin
            req_done_q[grant_id_q] <= 1'b1;
            rr_ptr_q               <= rr_ptr_d;
            arb_busy_q             <= 1'b0;
            state_q                <= IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          arb_busy_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready = req_ready;
  assign req_if.req_done  = req_done_q;
  assign tx_start_o       = tx_start_q;
  assign tx_data_o        = tx_data_q;
  assign tx_conf_o        = tx_conf_q;
  assign grant_id_o       = grant_id_q;
  assign arb_busy_o       = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with NUM_REQ=4. tx_module behaviour
// (busy/done) is driven step by step from the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int C = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_busy;
  logic         tx_done;
  logic         tx_start;
  logic [W-1:0] tx_data;
  logic [C-1:0] tx_conf;
  logic [1:0]   grant_id;
  logic         arb_busy;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter_if #(.NUM_REQ(N), .MAX_UART_DATA_W(W), .TOTAL_CONF_WIDTH(C)) rif ();

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_UART_DATA_W(W), .TOTAL_CONF_WIDTH(C)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_if     (rif),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .tx_conf_o  (tx_conf),
    .tx_busy_i  (tx_busy),
    .tx_done_i  (tx_done),
    .grant_id_o (grant_id),
    .arb_busy_o (arb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_data(input int r);
    return W'(8'hA0 + r);
  endfunction

  function automatic logic [C-1:0] exp_conf(input int r);
    return C'(3 * r + 4);
  endfunction

  task automatic load_defaults();
    for (int r = 0; r < N; r++) begin
      rif.req_data[r*W +: W] = exp_data(r);
      rif.req_conf[r*C +: C] = exp_conf(r);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_start"}, 32'(tx_start), 32'd0);
    check({pfx, "_data"},  32'(tx_data),  32'd0);
    check({pfx, "_conf"},  32'(tx_conf),  32'd0);
    check({pfx, "_ready"}, 32'(rif.req_ready), 32'd0);
    check({pfx, "_done"},  32'(rif.req_done),  32'd0);
    check({pfx, "_grant"}, 32'(grant_id), 32'd0);
    check({pfx, "_abusy"}, 32'(arb_busy), 32'd0);
  endtask

  // One complete frame for winner r, entered in an IDLE cycle with no
  // done pulse pending; leaves the FSM in IDLE one cycle after req_done.
  task automatic run_frame(input int r);
    logic [N-1:0] onehot;
    onehot = N'(1) << r;
    #1;
    check($sformatf("f%0d_ready", r), 32'(rif.req_ready), 32'(onehot));
    tick();
    check($sformatf("f%0d_start", r), 32'(tx_start), 32'd1);
    check($sformatf("f%0d_grant", r), 32'(grant_id), 32'(r));
    check($sformatf("f%0d_data", r),  32'(tx_data),  32'(exp_data(r)));
    check($sformatf("f%0d_conf", r),  32'(tx_conf),  32'(exp_conf(r)));
    check($sformatf("f%0d_rdy_busy", r), 32'(rif.req_ready), 32'd0);
    tx_busy = 1'b1;
    tick();
    check($sformatf("f%0d_start_off", r), 32'(tx_start), 32'd0);
    check($sformatf("f%0d_nodone", r), 32'(rif.req_done), 32'd0);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    check($sformatf("f%0d_done", r),  32'(rif.req_done), 32'(onehot));
    check($sformatf("f%0d_abusy", r), 32'(arb_busy), 32'd0);
    check($sformatf("f%0d_rdy_dc", r), 32'(rif.req_ready), 32'd0);
    tx_done = 1'b0;
    tick();
    check($sformatf("f%0d_done_off", r), 32'(rif.req_done), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    tx_busy       = 1'b0;
    tx_done       = 1'b0;
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_conf  = '0;
`ifdef UART_TX_ARB_LOCK_EN
    rif.req_lock  = '0;
`endif
    tick();
    tick();
    check_idle_outputs("rst");
    rst = 1'b0;

    // Single request from r2.
    load_defaults();
    rif.req_data[2*W +: W] = 8'h5A;
    rif.req_conf[2*C +: C] = 5'b11_00_1;
    rif.req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(rif.req_ready), 32'h4);
    tick();
    rif.req_valid = '0;
    rif.req_data[2*W +: W] = 8'hFF;
    #1;
    check("single_ready_off", 32'(rif.req_ready), 32'h0);
    check("single_start",     32'(tx_start), 32'd1);
    check("single_data",      32'(tx_data),  32'h5A);
    check("single_conf",      32'(tx_conf),  32'h19);
    check("single_grant",     32'(grant_id), 32'd2);
    check("single_abusy",     32'(arb_busy), 32'd1);
    tick();
    check("single_start_hold", 32'(tx_start), 32'd1);
    tx_busy = 1'b1;
    tick();
    check("single_start_off", 32'(tx_start), 32'd0);
    check("single_data_hold", 32'(tx_data),  32'h5A);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    check("single_done", 32'(rif.req_done), 32'h4);
    tx_done = 1'b0;
    tick();
    check("single_done_once", 32'(rif.req_done), 32'h0);

    // All four valid from reset: order 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_defaults();
    rif.req_valid = 4'b1111;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(0);

    // Slow baud: start held 16 cycles before tx_busy rises (rr_ptr=1).
    rif.req_valid = 4'b0010;
    #1;
    check("slow_ready", 32'(rif.req_ready), 32'h2);
    tick();
    rif.req_valid = '0;
    rif.req_data[1*W +: W] = 8'h3C;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("slow_start_%0d", i), 32'(tx_start), 32'd1);
      check($sformatf("slow_data_%0d", i),  32'(tx_data),  32'hA1);
      tick();
    end
    tx_busy = 1'b1;
    tick();
    check("slow_start_off", 32'(tx_start), 32'd0);
    check("slow_data_load", 32'(tx_data),  32'hA1);
    tick();
    check("slow_data_load2", 32'(tx_data), 32'hA1);
    load_defaults();

    // tx_done held high for 16 cycles: one pulse, next START waits for busy.
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    check("hold_done", 32'(rif.req_done), 32'h2);
    rif.req_valid = 4'b1000;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("hold_nodone_%0d", i), 32'(rif.req_done), 32'h0);
    end
    check("hold_start_wait", 32'(tx_start), 32'd1);
    check("hold_grant",      32'(grant_id), 32'd3);
    check("hold_data",       32'(tx_data),  32'hA3);
    rif.req_valid = '0;
    tx_done = 1'b0;
    tx_busy = 1'b1;
    tick();
    check("hold_start_off", 32'(tx_start), 32'd0);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    check("hold_done2", 32'(rif.req_done), 32'h8);
    tx_done = 1'b0;
    tick();

    // r2 frame moves rr_ptr to 3 before the mid-frame reset.
    rif.req_valid = 4'b0100;
    run_frame(2);

    // Reset during WAIT_DONE of r1.
    rif.req_valid = 4'b0010;
    #1;
    check("rstmid_ready", 32'(rif.req_ready), 32'h2);
    tick();
    tx_busy = 1'b1;
    tick();
    check("rstmid_abusy", 32'(arb_busy), 32'd1);
    check("rstmid_grant", 32'(grant_id), 32'd1);
    rst     = 1'b1;
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    check_idle_outputs("rstmid");
    rst     = 1'b0;
    tx_done = 1'b0;
    rif.req_valid = 4'b1010;
    #1;
    check("rstmid_nodone", 32'(rif.req_done), 32'h0);
    run_frame(1);

`ifdef UART_TX_ARB_LOCK_EN
    // r1 locked keeps priority over r3; served twice, then r3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rif.req_valid = 4'b1010;
    rif.req_lock  = 4'b0010;
    run_frame(1);
    rif.req_lock  = 4'b0000;
    run_frame(1);
    run_frame(3);
    rif.req_valid = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
